// File: rtl/sweep_arbiter.sv
// Two-requester round-robin arbiter that owns one up/down sweep counter.
// Latency: grant 1 cycle after request; first count value 1 cycle after grant.
// Backpressure: none downstream; requesters hold req until done, a dropped req aborts.
//
// Ports:
//   clk, n_rst    clock (rising edge), asynchronous active-low reset
//   req_i[1:0]    per-requester sweep request
//   dir_i[1:0]    per-requester direction, 1 = up (0..max), 0 = down (max..0)
//   gnt_o[1:0]    one-hot grant, 0 when no sweep is active
//   busy_o        high in every FSM state except IDLE
//   cnt_o         current count, 0 whenever cnt_vld_o is low
//   cnt_vld_o     cnt_o carries a sweep value
//   done_o[1:0]   one-cycle pulse to the owner on normal completion
module sweep_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       req_i,
  input  logic [1:0]       dir_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             cnt_vld_o,
  output logic [1:0]       done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  // Where a finished or aborted sweep goes, and whether busy stays up there.
  localparam state_t END_ST   = (GAP > 0) ? S_GAP : S_IDLE;
  localparam logic   END_BUSY = (GAP > 0);

  state_t           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic             busy_q;
  logic             vld_q;
  logic             dir_q;    // direction latched at grant
  logic             owner_q;  // index of the granted requester
  logic             last_q;   // last-served pointer
  logic [1:0]       req_q;    // registered requests, used for abort detection
  logic [WIDTH-1:0] cnt_q;
  logic [GW-1:0]    gap_q;

  logic win_d;
  logic own_req_d;
  logic at_term_d;

  always_comb begin
    // A lone requester wins outright; a tie goes to the one not served last.
    win_d = ~last_q;
    if (req_i == 2'b01) begin
      win_d = 1'b0;
    end else if (req_i == 2'b10) begin
      win_d = 1'b1;
    end
    own_req_d = req_q[owner_q];
    at_term_d = dir_q ? (cnt_q == CNT_MAX) : (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      dir_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      req_q  <= req_i;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_i != 2'b00) begin
            state_q <= S_LOAD;
            owner_q <= win_d;
            last_q  <= win_d;
            dir_q   <= dir_i[win_d];
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD, S_RUN: begin
          // Abort is checked first so it wins over a same-cycle completion.
          if (!own_req_d || (state_q == S_RUN && at_term_d)) begin
            state_q <= END_ST;
            busy_q  <= END_BUSY;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            if (own_req_d) begin
              done_q[owner_q] <= 1'b1;
            end
          end else if (state_q == S_LOAD) begin
            state_q <= S_RUN;
            cnt_q   <= dir_q ? '0 : CNT_MAX;
            vld_q   <= 1'b1;
          end else begin
            cnt_q <= dir_q ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          vld_q   <= 1'b0;
          cnt_q   <= '0;
          gap_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign cnt_o     = cnt_q;
  assign cnt_vld_o = vld_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_sweep_arbiter.sv
// Scoreboard bench for sweep_arbiter: the driver queues expected grants,
// count values and done pulses; a negedge monitor pops and compares them.
module tb_sweep_arbiter;

  localparam int W    = 4;
  localparam int NVAL = 2 ** W;

  logic         clk   = 1'b0;
  logic         n_rst = 1'b0;
  logic [1:0]   req   = 2'b00;
  logic [1:0]   dir   = 2'b00;
  logic [1:0]   gnt_o;
  logic         busy_o;
  logic [W-1:0] cnt_o;
  logic         cnt_vld_o;
  logic [1:0]   done_o;

  sweep_arbiter #(.WIDTH(W), .GAP(1)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_i     (req),
    .dir_i     (dir),
    .gnt_o     (gnt_o),
    .busy_o    (busy_o),
    .cnt_o     (cnt_o),
    .cnt_vld_o (cnt_vld_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   gnt;
    logic [W-1:0] cnt;
  } cnt_exp_t;

  typedef struct packed {
    logic [1:0] gnt;
    int         period;  // cycles since previous grant, 0 = not checked
  } gnt_exp_t;

  cnt_exp_t   cq[$];
  gnt_exp_t   gq[$];
  logic [1:0] dq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_gnt_cyc = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic       prev_vld = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sweep(input logic [1:0] g, input logic up, input int n);
    for (int i = 0; i < n; i++) begin
      cnt_exp_t e;
      e.gnt = g;
      e.cnt = up ? W'(i) : W'(NVAL - 1 - i);
      cq.push_back(e);
    end
  endtask

  task automatic push_gnt(input logic [1:0] g, input int period);
    gnt_exp_t e;
    e.gnt    = g;
    e.period = period;
    gq.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_o != 2'b00) return;
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
  endtask

  task automatic wait_cnt(input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (cnt_vld_o && int'(cnt_o) == val) return;
    end
    tests++;
    fails++;
    $display("FAIL cnt_timeout: cnt %0d not seen within %0d cycles", val, budget);
  endtask

  // Called right after the done edge: busy holds through GAP, drops in IDLE.
  task automatic check_busy_tail();
    check("busy_in_gap", int'(busy_o), 1);
    @(posedge clk); #1;
    check("busy_idle", int'(busy_o), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (n_rst) begin
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
        if (gq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL grant_unexpected: got gnt=%b, expected none", gnt_o);
        end else begin
          gnt_exp_t ge;
          ge = gq.pop_front();
          check("grant_value", int'(gnt_o), int'(ge.gnt));
          check("grant_busy", int'(busy_o), 1);
          if (ge.period != 0) check("grant_period", cyc - last_gnt_cyc, ge.period);
        end
        last_gnt_cyc = cyc;
      end
      if (cnt_vld_o) begin
        if (!prev_vld) check("first_vld_latency", cyc - last_gnt_cyc, 1);
        if (cq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cnt_unexpected: got cnt=%0d, expected none", cnt_o);
        end else begin
          cnt_exp_t ce;
          ce = cq.pop_front();
          check("cnt_value", int'(cnt_o), int'(ce.cnt));
          check("cnt_gnt", int'(gnt_o), int'(ce.gnt));
        end
      end
      if (prev_vld && !cnt_vld_o) begin
        check("cnt_zero_after_vld", int'(cnt_o), 0);
        check("gnt_zero_after_vld", int'(gnt_o), 0);
      end
      if (done_o != 2'b00) begin
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got done=%b, expected none", done_o);
        end else begin
          logic [1:0] de;
          de = dq.pop_front();
          check("done_value", int'(done_o), int'(de));
          check("done_latency", cyc - last_gnt_cyc, NVAL + 1);
        end
      end
    end
    prev_gnt = gnt_o;
    prev_vld = cnt_vld_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", int'(gnt_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_cnt", int'(cnt_o), 0);
    check("rst_vld", int'(cnt_vld_o), 0);
    check("rst_done", int'(done_o), 0);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Up sweep, requester 0.
    push_gnt(2'b01, 0);
    push_sweep(2'b01, 1'b1, NVAL);
    dq.push_back(2'b01);
    dir = 2'b01;
    req = 2'b01;
    wait_done(40);
    req = 2'b00;
    check_busy_tail();
    repeat (3) @(posedge clk);
    #1;

    // Down sweep, requester 1.
    push_gnt(2'b10, 0);
    push_sweep(2'b10, 1'b0, NVAL);
    dq.push_back(2'b10);
    dir = 2'b00;
    req = 2'b10;
    wait_done(40);
    req = 2'b00;
    check_busy_tail();
    repeat (3) @(posedge clk);
    #1;

    // Continuous tie: grants alternate starting with requester 0, 19 cycles apart.
    dir = 2'b01;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      push_gnt(g, (i == 0) ? 0 : NVAL + 3);
      push_sweep(g, (i % 2 == 0), NVAL);
      dq.push_back(g);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done(40);
    req = 2'b00;
    check_busy_tail();
    repeat (3) @(posedge clk);
    #1;

    // Abort: requester 0 drops req while cnt=5; pending requester 1 follows.
    push_gnt(2'b01, 0);
    push_sweep(2'b01, 1'b1, 7);
    push_gnt(2'b10, 10);
    push_sweep(2'b10, 1'b0, NVAL);
    dq.push_back(2'b10);
    dir = 2'b01;
    req = 2'b01;
    wait_cnt(2, 10);
    req = 2'b11;
    wait_cnt(5, 10);
    req = 2'b10;
    @(posedge clk); #1;
    check("abort_still_vld", int'(cnt_vld_o), 1);
    check("abort_cnt6", int'(cnt_o), 6);
    @(posedge clk); #1;
    check("abort_vld_low", int'(cnt_vld_o), 0);
    check("abort_gnt_low", int'(gnt_o), 0);
    check("abort_no_done", int'(done_o), 0);
    wait_done(40);
    req = 2'b00;
    check_busy_tail();
    repeat (3) @(posedge clk);
    #1;

    // Direction changes mid-sweep are ignored.
    push_gnt(2'b01, 0);
    push_sweep(2'b01, 1'b1, NVAL);
    dq.push_back(2'b01);
    dir = 2'b01;
    req = 2'b01;
    wait_cnt(3, 10);
    dir = 2'b00;
    wait_cnt(8, 10);
    dir = 2'b10;
    wait_done(40);
    req = 2'b00;
    dir = 2'b00;
    check_busy_tail();
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-sweep, then a tie must go to requester 0 again.
    push_gnt(2'b01, 0);
    push_sweep(2'b01, 1'b1, NVAL);
    dq.push_back(2'b01);
    dir = 2'b01;
    req = 2'b01;
    wait_cnt(9, 20);
    n_rst = 1'b0;
    #1;
    check("mid_rst_gnt", int'(gnt_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_cnt", int'(cnt_o), 0);
    check("mid_rst_vld", int'(cnt_vld_o), 0);
    check("mid_rst_done", int'(done_o), 0);
    cq.delete();
    gq.delete();
    dq.delete();
    push_gnt(2'b01, 0);
    push_sweep(2'b01, 1'b1, NVAL);
    dq.push_back(2'b01);
    req = 2'b11;
    dir = 2'b11;
    @(posedge clk); #1;
    n_rst = 1'b1;
    wait_done(40);
    req = 2'b00;
    check_busy_tail();
    repeat (5) @(posedge clk);
    #1;

    check("cnt_queue_empty", cq.size(), 0);
    check("gnt_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
